// File: rtl/binary_mul_pkg.sv
// ---------------------------------------------------------------------------
// binary_mul_pkg : shared types and helpers for the shift-add multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package binary_mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter must address bits 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/binary_mul_addsub.sv
// ---------------------------------------------------------------------------
// binary_mul_addsub : accumulator +/- one extended, shifted partial product
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module binary_mul_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic               b_bit_i,
  input  logic               signed_i,
  input  logic [CNT_W-1:0]   shift_i,
  input  logic               sub_i,
  output logic [2*WIDTH-1:0] sum_o
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] pp;

  always_comb begin
    a_ext = signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    pp    = b_bit_i ? (a_ext << shift_i) : '0;
    // Subtraction realises the negative weight of B's MSB in signed mode.
    sum_o = sub_i ? (acc_i - pp) : (acc_i + pp);
  end

endmodule

`default_nettype wire

// File: rtl/binary_mul_seq.sv
// ---------------------------------------------------------------------------
// binary_mul_seq : WIDTH-cycle shift-add multiplier, signed/unsigned per op
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module binary_mul_seq
  import binary_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic               last_step;
  logic [2*WIDTH-1:0] acc_next;

  assign last_step = (cnt_q == LAST_CNT);

  binary_mul_addsub #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_addsub (
    .acc_i    (acc_q),
    .a_i      (a_q),
    .b_bit_i  (b_q[cnt_q]),
    .signed_i (sgn_q),
    .shift_i  (cnt_q),
    .sub_i    (sgn_q & last_step),
    .sum_o    (acc_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    product_d = product_q;
    done_d    = done_q;

    // With en low every register keeps its value, including the done pulse.
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = a_in;
            b_d     = b_in;
            sgn_d   = signed_mode;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            product_d = acc_next;
            done_d    = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire

// File: doc/binary_mul_seq.md
Name: binary_mul_seq

Overview:
- Parametrised sequential (shift-add) multiplier; the next generation of the team's small array multipliers.
- Handles WIDTH-bit operands, signed or unsigned per operation, with a full-precision 2*WIDTH-bit product (no truncated MSB).
- Uses a start/done handshake and an en stall input.
- Sits next to the combinational array multipliers as the area-cheap option for datapaths that tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low, all internal state and outputs hold
- start  in  1  request new operation; sampled only when en=1 and busy=0
- signed_mode  in  1  1: two's-complement operands; 0: unsigned; latched with start
- a_in  in  WIDTH  multiplicand; latched with start
- b_in  in  WIDTH  multiplier; latched with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, product valid and updated
- product  out  2*WIDTH  last completed result; held until next completion

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, accumulator/counter=0. Reset mid-operation aborts it; product does not update.
- States: IDLE, RUN.
- IDLE:
  - If en=1 and start=1: latch a_in, b_in, signed_mode; clear accumulator; cnt=0; go to RUN; busy=1 from next cycle.
  - Otherwise: busy=0.
- RUN, each edge with en=1, processing bit i=cnt of latched B:
  - Partial product = B[i] ? A : 0, extended to 2*WIDTH (sign-extended if signed_mode, zero-extended otherwise), shifted left by i.
  - For i<WIDTH-1, or unsigned mode: acc += partial product.
  - For i=WIDTH-1 in signed mode: acc -= partial product. B's MSB weight is negative.
  - All arithmetic is modulo 2^(2*WIDTH).
  - cnt increments. On the step with cnt=WIDTH-1: product <= final acc, done <= 1, go to IDLE.
- Latency: if start is accepted at edge k, steps occur at edges k+1..k+WIDTH, and product/done update at edge k+WIDTH. With en held high, done is high for exactly the one cycle after edge k+WIDTH. busy is high between edges k and k+WIDTH and low when done is high.
- done: high for exactly one cycle per completed operation. If en=0 in the cycle done is high, done stays high until the next en=1 edge. done clears at the next en=1 edge unless that edge completes another operation (impossible for WIDTH>=2).
- Back-to-back: start in the cycle done=1 is accepted (state is IDLE). Throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored, no queueing. Input changes after acceptance are ignored, including signed_mode.
- en=0: freezes state, cnt, acc, busy, done, product. Each en-low cycle extends latency by one.
- Extremes (WIDTH=8):
  - Unsigned 255*255 = 0xFE01.
  - Signed (-128)*(-128) = 0x4000.
  - Signed (-128)*127 = 0xC080.
  - All fit with no overflow.

Decomposition:
- Package binary_mul_pkg: state enum {IDLE, RUN}, function computing the counter width clog2(WIDTH), default WIDTH constant.
- Sub-module binary_mul_addsub: combinational 2*WIDTH-bit add/subtract of the shifted, extended partial product, with sub select = signed_mode & (cnt==WIDTH-1).
- FSM, counter and registers stay in binary_mul_seq.

Test Plan (WIDTH=8):
1. Unsigned: a=255, b=255, start at edge k -> done pulse after edge k+8, product=0xFE01, busy high for 8 cycles.
2. Signed: (-128)*(-128) -> 0x4000; (-3)*5 -> 0xFFF1; 0x80 as unsigned times 2 -> 0x0100.
3. Stall: signed 7*(-6), en low for 3 cycles mid-RUN -> done 3 cycles later than nominal, product=0xFFD6; outputs frozen during the stall.
4. start pulsed with new operands while busy -> ignored, first result unchanged. start in the done cycle -> accepted, second result correct after 8 more cycles.
5. rst asserted mid-RUN (cycle 4) after a previous result of 0x1234 -> product=0, busy=0, done=0 immediately. No done pulse follows; a new op of 12*12 after release -> 0x0090.
6. a=0 or b=0, both modes -> product=0 with normal timing; signed_mode toggled after start -> no effect on the result.
